// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer and its memory controller.
// State codes double as the {eop,sop} phase code seen by the controller.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_PROC = 2'b01,
        ST_OUT  = 2'b10,
        ST_IDLE = 2'b11
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/xfer_cnt.sv
// Word/column counter with a wrap strobe and a count of completed blocks.
// A synchronous clear has priority over stepping.
module xfer_cnt
    import conv_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = (clog2(W) > 0) ? clog2(W) : 1,
    parameter int BW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          step_i,
    output logic [CW-1:0] col_o,
    output logic          wrap_o,
    output logic [BW-1:0] blk_o
);

    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

    logic [CW-1:0] col_q, col_d;
    logic [BW-1:0] blk_q, blk_d;

    assign wrap_o = step_i && (col_q == COL_LAST);
    assign col_o  = col_q;
    assign blk_o  = blk_q;

    always_comb begin
        col_d = col_q;
        blk_d = blk_q;
        if (clr_i) begin
            col_d = '0;
            blk_d = '0;
        end else if (step_i) begin
            col_d = wrap_o ? '0 : col_q + 1'b1;
            if (wrap_o) blk_d = blk_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            blk_q <= '0;
        end else begin
            col_q <= col_d;
            blk_q <= blk_d;
        end
    end

endmodule

// File: rtl/conv_seq.sv
// Frame sequencer: LOAD line blocks, wait for the datapath in PROC, drain one row in OUT.
// The first LOAD of a frame primes N+1 line memories; later rows load one block each.
module conv_seq
    import conv_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int IMG_W = 8,
    parameter  int NROWS = 4,
    localparam int CW    = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic          i_proc_done,
    input  logic          i_rd_ready,
    output logic          o_rd_valid,
    output logic          o_sop,
    output logic          o_eop,
    output logic          o_chblk,
    output logic [CW-1:0] o_col,
    output logic          o_busy,
    output logic          o_frame_done
);

    localparam int BW = (clog2(N + 2) > 0) ? clog2(N + 2) : 1;
    localparam int RW = (clog2(NROWS + 1) > 0) ? clog2(NROWS + 1) : 1;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic          chblk_q, chblk_d;
    logic          done_q, done_d;
    logic          step, wrap, clr, last_blk;
    logic [BW-1:0] blk, blk_last_idx;

    assign o_wr_ready = (state_q == ST_LOAD);
    assign o_rd_valid = (state_q == ST_OUT);
    assign step       = (i_wr_valid && o_wr_ready) || (o_rd_valid && i_rd_ready);

    // row_q == 0 identifies the first LOAD of a frame, which fills N+1 blocks.
    assign blk_last_idx = (state_q == ST_LOAD && row_q == '0) ? BW'(N) : '0;
    assign last_blk     = wrap && (blk == blk_last_idx);
    assign clr          = i_abort || (state_d != state_q);

    xfer_cnt #(.W(IMG_W), .CW(CW), .BW(BW)) u_xfer_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .step_i (step),
        .col_o  (o_col),
        .wrap_o (wrap),
        .blk_o  (blk)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        chblk_d = 1'b0;
        done_d  = 1'b0;
        if (i_abort) begin
            state_d = ST_IDLE;
            row_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) state_d = ST_LOAD;
                ST_LOAD: begin
                    chblk_d = wrap && !last_blk;
                    if (last_blk) state_d = ST_PROC;
                end
                ST_PROC: if (i_proc_done) state_d = ST_OUT;
                ST_OUT: begin
                    chblk_d = wrap && !last_blk;
                    if (last_blk) begin
                        if (row_q == RW'(NROWS - 1)) begin
                            state_d = ST_IDLE;
                            row_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            row_d   = row_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            chblk_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            chblk_q <= chblk_d;
            done_q  <= done_d;
        end
    end

    assign o_sop        = state_q[0];
    assign o_eop        = state_q[1];
    assign o_chblk      = chblk_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = done_q;

endmodule
